// File: rtl/imager_seq_pkg.sv
// imager_seq_pkg: shared encodings for the frame sequencer.
// One-hot states, debug status codes and the address-width helper.
package imager_seq_pkg;

  localparam int I_IDLE    = 0;
  localparam int I_LOAD    = 1;
  localparam int I_RUN1    = 2;
  localparam int I_EXPOSE  = 3;
  localparam int I_READOUT = 4;
  localparam int I_RELEASE = 5;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_LOAD    = 6'b000010,
    S_RUN1    = 6'b000100,
    S_EXPOSE  = 6'b001000,
    S_READOUT = 6'b010000,
    S_RELEASE = 6'b100000
  } state_t;

  localparam logic [7:0] ST_IDLE    = 8'hF0;
  localparam logic [7:0] ST_LOAD    = 8'hF1;
  localparam logic [7:0] ST_RUN1    = 8'hF2;
  localparam logic [7:0] ST_EXPOSE  = 8'hF3;
  localparam logic [7:0] ST_READOUT = 8'hF4;
  localparam logic [7:0] ST_RELEASE = 8'hF5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/imager_frame_sequencer_if.sv
// Exposure-FSM side of the frame sequencer.
// master = sequencer, slave = exposure/ADC FSM pair.
interface imager_frame_sequencer_if;

  logic        FSMIND0;
  logic        FSMIND0ACK;
  logic        FSMIND1;
  logic        FSMIND1ACK;
  logic        RO_DONE;
  logic        EXP_RESET;
  logic [31:0] Exp_subc;
  logic [31:0] Num_Pat;

  modport master (
    output FSMIND0, EXP_RESET, Exp_subc, Num_Pat,
    input  FSMIND0ACK, FSMIND1, FSMIND1ACK, RO_DONE
  );

  modport slave (
    input  FSMIND0, EXP_RESET, Exp_subc, Num_Pat,
    output FSMIND0ACK, FSMIND1, FSMIND1ACK, RO_DONE
  );

endinterface

// File: rtl/imager_cfg_table.sv
// Host-written exposure table: {exp, npat} per entry.
// Synchronous write, combinational read, contents survive reset.
module imager_cfg_table
  import imager_seq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          CLKMPRE,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // host write port
  always_ff @(posedge CLKMPRE) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imager_frame_sequencer.sv
// imager_frame_sequencer: frame-level scheduler for the exposure FSM.
// Steps the config table per frame and closes the FSMIND0 release loop.
module imager_frame_sequencer
  import imager_seq_pkg::*;
#(
  parameter  int          C_CFG_DEPTH = 4,
  parameter  logic [31:0] C_TIMEOUT   = 32'd50_000_000,
  localparam int          AW          = clog2(C_CFG_DEPTH)
) (
  input  logic          CLKMPRE,
  input  logic          RESET,
  input  logic          CFG_WE,
  input  logic [AW-1:0] CFG_ADDR,
  input  logic [31:0]   CFG_EXP,
  input  logic [31:0]   CFG_NPAT,
  input  logic [7:0]    NUM_CFG,
  input  logic [31:0]   NUM_FRAMES,
  input  logic          START,
  input  logic          STOP,
  imager_frame_sequencer_if.master fsm,
  output logic [AW-1:0] CFG_IDX,
  output logic [31:0]   FRAME_CNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR_TIMEOUT,
  output logic [7:0]    seq_stat
);

  localparam logic [AW:0] DEPTH_L = C_CFG_DEPTH[AW:0];

  state_t        state_q, state_d;
  logic [31:0]   exp_q, npat_q, fcnt_q, wd_q;
  logic [AW-1:0] idx_q, idx_nxt;
  logic [AW:0]   ncfg, inc;
  logic [63:0]   rd;
  logic          exp_rst_q, done_q, err_q, stop_q, first_q;
  logic          go, count, finish, timeout, wd_hit, waiting;
  logic [31:0]   fcnt_inc;

  imager_cfg_table #(.DEPTH(C_CFG_DEPTH)) u_tab (
    .CLKMPRE (CLKMPRE),
    .we      (CFG_WE),
    .waddr   (CFG_ADDR),
    .wdata   ({CFG_EXP, CFG_NPAT}),
    .raddr   (idx_q),
    .rdata   (rd)
  );

  assign fcnt_inc = fcnt_q + 32'd1;
  assign waiting  = state_q[I_EXPOSE] | state_q[I_READOUT]
                  | state_q[I_RELEASE];
  assign wd_hit   = (C_TIMEOUT != 32'd0)
                  && (wd_q == C_TIMEOUT - 32'd1);

  // effective table length: 0 acts as 1, clamp to depth
  always_comb begin
    ncfg = NUM_CFG[AW:0];
    if (NUM_CFG == 8'd0)
      ncfg = {{AW{1'b0}}, 1'b1};
    else if ({1'b0, NUM_CFG} > 9'(C_CFG_DEPTH))
      ncfg = DEPTH_L;
    inc     = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};
    idx_nxt = (inc >= ncfg) ? '0 : inc[AW-1:0];
  end

  // state register
  always_ff @(posedge CLKMPRE) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state; handshake events beat the watchdog
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    count   = 1'b0;
    finish  = 1'b0;
    timeout = 1'b0;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (START) begin
          state_d = S_LOAD;
          go      = 1'b1;
        end
      end
      state_q[I_LOAD]: begin
        state_d = first_q ? S_RUN1 : S_RELEASE;
      end
      state_q[I_RUN1]: begin
        state_d = S_EXPOSE;
      end
      state_q[I_EXPOSE]: begin
        if (fsm.FSMIND1 && fsm.FSMIND1ACK) begin
          state_d = S_READOUT;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      state_q[I_READOUT]: begin
        if (fsm.RO_DONE) begin
          count = 1'b1;
          if (stop_q || STOP ||
              (NUM_FRAMES != 32'd0 &&
               fcnt_inc == NUM_FRAMES)) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end else if (wd_hit) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      state_q[I_RELEASE]: begin
        if (fsm.FSMIND0ACK) begin
          state_d = S_EXPOSE;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // datapath, counters, flags and watchdog
  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      exp_q     <= '0;
      npat_q    <= '0;
      idx_q     <= '0;
      fcnt_q    <= '0;
      wd_q      <= '0;
      exp_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      stop_q    <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (state_d != state_q || !waiting)
        wd_q <= '0;
      else
        wd_q <= wd_q + 32'd1;
      if (go) begin
        fcnt_q  <= '0;
        idx_q   <= '0;
        err_q   <= 1'b0;
        stop_q  <= 1'b0;
        first_q <= 1'b1;
      end else if (STOP && !state_q[I_IDLE]) begin
        stop_q <= 1'b1;
      end
      if (state_q[I_LOAD]) begin
        exp_q   <= rd[63:32];
        npat_q  <= rd[31:0];
        first_q <= 1'b0;
      end
      if (state_q[I_RUN1]) exp_rst_q <= 1'b0;
      if (count) begin
        fcnt_q <= fcnt_inc;
        if (!finish) idx_q <= idx_nxt;
      end
      if (finish) exp_rst_q <= 1'b1;
      if (timeout) begin
        exp_rst_q <= 1'b1;
        err_q     <= 1'b1;
      end
    end
  end

  // debug state code
  always_comb begin
    seq_stat = ST_IDLE;
    unique case (1'b1)
      state_q[I_IDLE]:    seq_stat = ST_IDLE;
      state_q[I_LOAD]:    seq_stat = ST_LOAD;
      state_q[I_RUN1]:    seq_stat = ST_RUN1;
      state_q[I_EXPOSE]:  seq_stat = ST_EXPOSE;
      state_q[I_READOUT]: seq_stat = ST_READOUT;
      state_q[I_RELEASE]: seq_stat = ST_RELEASE;
      default:            seq_stat = ST_IDLE;
    endcase
  end

  assign fsm.FSMIND0   = state_q[I_RELEASE];
  assign fsm.EXP_RESET = exp_rst_q;
  assign fsm.Exp_subc  = exp_q;
  assign fsm.Num_Pat   = npat_q;
  assign CFG_IDX       = idx_q;
  assign FRAME_CNT     = fcnt_q;
  assign BUSY          = !state_q[I_IDLE];
  assign DONE          = done_q;
  assign ERR_TIMEOUT   = err_q;

endmodule
